mic_period_meter: RTL



---
 rtl/mic_meter_pkg.sv | 20 ++
 rtl/schmitt_trigger.sv | 36 +++
 rtl/mic_period_meter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mic_meter_pkg.sv
// Shared types and constants for the microphone period meter.
// Defaults here seed the top-level parameters.
package mic_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam int def_w_period = 20;
    localparam int def_log2_avg = 2;
    localparam int def_sat      = (2 ** def_w_period) - 1;
    localparam int def_sum_w    = def_w_period + def_log2_avg;

    function automatic int sum_width(input int w_period, input int log2_avg);
        return w_period + log2_avg;
    endfunction

endpackage

// File: rtl/schmitt_trigger.sv
// Hysteresis comparator on signed samples.
// Registers the level and a one-cycle rising-transition flag.
module schmitt_trigger #(
    parameter int w_mic = 24,
    parameter int hyst  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [w_mic-1:0] sample,
    output logic                    rise,
    output logic                    level
);

    localparam logic signed [w_mic-1:0] th_hi = w_mic'(hyst);
    localparam logic signed [w_mic-1:0] th_lo = w_mic'(-hyst);

    logic go_high;
    logic go_low;

    assign go_high = !level && (sample > th_hi);
    assign go_low  = level && (sample < th_lo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= go_high;
            if (go_high)
                level <= 1'b1;
            else if (go_low)
                level <= 1'b0;
        end
    end

endmodule

// File: rtl/mic_period_meter.sv
// Averaged zero-crossing period meter for raw microphone samples.
// Rejects glitch crossings and reports silence on counter timeout.
module mic_period_meter
    import mic_meter_pkg::*;
#(
    parameter int w_mic      = 24,
    parameter int w_period   = def_w_period,
    parameter int hyst       = 1024,
    parameter int min_period = 64,
    parameter int log2_avg   = def_log2_avg
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [w_mic-1:0] mic,
    output logic [w_period-1:0]     period,
    output logic                    period_valid,
    output logic                    silent,
    output logic                    crossing
);

    localparam int sum_w = sum_width(w_period, log2_avg);
    localparam int n_w   = log2_avg + 1;
    localparam logic [w_period-1:0] sat    = '1;
    localparam logic [w_period-1:0] min_p  = w_period'(min_period);
    localparam logic [n_w-1:0]      n_full = n_w'(2 ** log2_avg);

    logic signed [w_mic-1:0] mic_q;
    logic                    rise;
    logic                    level;

    state_t              state, state_n;
    logic [w_period-1:0] cnt, cnt_n;
    logic [sum_w-1:0]    sum, sum_n;
    logic [n_w-1:0]      n, n_n;
    logic [w_period-1:0] period_n;
    logic                valid_n;
    logic                silent_n;

    logic             ev;
    logic             accept;
    logic             timeout;
    logic [sum_w-1:0] total;
    logic [n_w-1:0]   n_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mic_q <= '0;
        else
            mic_q <= mic;
    end

    schmitt_trigger #(
        .w_mic (w_mic),
        .hyst  (hyst)
    ) u_schmitt (
        .clk    (clk),
        .rst    (rst),
        .sample (mic_q),
        .rise   (rise),
        .level  (level)
    );

    // rise is only raised together with level going high
    assign ev       = rise && level;
    assign accept   = ev && ((state == IDLE) || (cnt >= min_p));
    assign timeout  = (state != IDLE) && (cnt == sat);
    assign total    = sum + sum_w'(cnt);
    assign n_inc    = n + 1'b1;
    assign crossing = accept;

    always_comb begin
        state_n  = state;
        cnt_n    = (cnt == sat) ? cnt : cnt + 1'b1;
        sum_n    = sum;
        n_n      = n;
        period_n = period;
        valid_n  = 1'b0;
        silent_n = silent;
        unique case (1'b1)
            accept: begin
                cnt_n = w_period'(1);
                unique case (state)
                    IDLE: begin
                        state_n = ARM;
                        sum_n   = '0;
                        n_n     = '0;
                    end
                    ARM, MEASURE: begin
                        if (n_inc == n_full) begin
                            state_n  = MEASURE;
                            period_n = w_period'(total >> log2_avg);
                            valid_n  = 1'b1;
                            silent_n = 1'b0;
                            sum_n    = '0;
                            n_n      = '0;
                        end else begin
                            sum_n = total;
                            n_n   = n_inc;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
            timeout: begin
                state_n  = IDLE;
                silent_n = 1'b1;
                sum_n    = '0;
                n_n      = '0;
                if (state == MEASURE) begin
                    period_n = '0;
                    valid_n  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sum          <= '0;
            n            <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            silent       <= 1'b1;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            sum          <= sum_n;
            n            <= n_n;
            period       <= period_n;
            period_valid <= valid_n;
            silent       <= silent_n;
        end
    end

endmodule
